seg7_bin_display: RTL and testbench
===================================

// Module: seg7_bin_display
// PURPOSE
//  Multi-digit 7-segment display driver, successor to the single-digit hex decoder.
//  Converts a WIDTH-bit unsigned value to DIGITS decimal digits with a sequential
//  shift-add-3 (double-dabble) engine, or to hex nibbles in bypass mode.
//  Optional leading-zero blanking. Holds the displayed value until the next
//  conversion completes. Drives the DE2 HEX displays (segments active-low).
// PARAMETERS
//  WIDTH    16  binary input width, 4..32
//  DIGITS   5   output digit count; requires 10**DIGITS >= 2**WIDTH
//  LZ_BLANK 1   1 = blank leading-zero digits (digit 0 never blanked)
// PORTS
//  iCLK_50   in   1         system clock, 50 MHz
//  iRST_N    in   1         async active-low reset
//  iBIN      in   WIDTH     unsigned value to display
//  iLOAD     in   1         start request; sampled only in IDLE
//  iHEX_MODE in   1         0 = decimal, 1 = hex nibbles; sampled with iLOAD
//  oBUSY     out  1         high while a conversion is in progress
//  oDONE     out  1         one-cycle pulse when display registers update
//  oSEG      out  7*DIGITS  digit k on oSEG[7k+6:7k]; bit0=a..bit6=g; active-low
// BEHAVIOUR
//  Clocking: one clock (iCLK_50), async active-low reset iRST_N; all state resets immediately.
//  Reset values:
//   - state IDLE; oBUSY=0; oDONE=0; digit registers = 0.
//   - oSEG: digit0 = 7'h40; other digits = 7'h7F if LZ_BLANK, else 7'h40.
//  FSM IDLE -> SHIFT -> DONE -> IDLE:
//   - IDLE: iLOAD=1 captures iBIN and iHEX_MODE.
//     - Decimal: go to SHIFT; clear BCD scratch; bit counter = WIDTH.
//     - Hex: go to DONE.
//   - SHIFT: each cycle, add 3 to every BCD nibble >= 5, then shift {bcd,bin} left by 1.
//     Decrement counter; leave for DONE after exactly WIDTH cycles.
//   - DONE: one cycle. Copy scratch (decimal) or the captured nibbles (hex) to the digit
//     registers. oDONE=1 this cycle; return to IDLE.
//  oBUSY=1 in SHIFT and DONE, 0 in IDLE.
//  Latency, with load accepted at edge N:
//   - decimal: oDONE high in cycle N+WIDTH+1;
//   - hex: oDONE high in cycle N+1.
//  Back-to-back: iLOAD held high restarts in the IDLE cycle after DONE.
//   - Throughput: decimal one conversion per WIDTH+2 cycles; hex one per 2 cycles.
//  iLOAD while oBUSY=1 is ignored (no queueing); iBIN/iHEX_MODE changes mid-conversion have no effect.
//  Display registers change only in DONE; oSEG never shows partial results.
//  Hex mode:
//   - digit k = iBIN[4k+3:4k], zero-extended above WIDTH;
//   - bits beyond 4*DIGITS are truncated.
//  Scratch register widths:
//   - BCD scratch is 4*DIGITS bits, no overflow possible given the parameter rule;
//   - the add-3 compare is on 4-bit nibbles only.
//  Leading-zero blanking (LZ_BLANK=1):
//   - digit k (k>0) is blanked (7'h7F) if it and all digits above it are 0;
//   - applies in both modes.
//  Decoder (gfedcba, active-low):
//   0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E
//  Reset mid-conversion:
//   - aborts and returns to reset values;
//   - no oDONE pulse for the aborted conversion.
//  oSEG is combinational from the digit registers (no added latency).
// TESTING (WIDTH=16, DIGITS=5, LZ_BLANK=1)
//  T1:
//   - Stimulus: iBIN=12345, dec, iLOAD 1 cycle.
//   - Response: oBUSY high 17 cycles; oDONE 17 cycles after load edge.
//   - oSEG digits4..0 = 79,24,30,19,12.
//  T2:
//   - Stimulus: iBIN=65535 dec.
//   - Response: digits = 02,12,12,30,12.
//   - Then iBIN=0 dec: digits4..1 = 7F, digit0 = 40.
//  T3:
//   - Stimulus: iBIN=16'hBEEF, iHEX_MODE=1.
//   - Response: oDONE next cycle; digits = 7F,03,06,06,0E.
//  T4:
//   - Stimulus: load 100 dec; pulse iLOAD with iBIN=999 at cycle 5 of SHIFT.
//   - Response: result shows 7F,7F,79,40,40; a single oDONE.
//  T5:
//   - Stimulus: load 4321 dec; drop iRST_N at cycle 8.
//   - Response: immediate reset values; no oDONE.
//   - After release, load 7: digit0 = 78, others 7F.
//  T6:
//   - Stimulus: iLOAD held high, alternating 9 and 90.
//   - Response: oDONE every 18 cycles; oSEG alternates 10 / 10,40 with no intermediate values.

Source files
------------

// File: rtl/seg7_bin_display.sv
// Multi-digit 7-segment driver: sequential double-dabble binary-to-BCD or hex bypass,
// optional leading-zero blanking, active-low segments for the DE2 HEX displays.

module seg7_digit (
  input  logic [3:0] i_nib,
  input  logic       i_blank,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = 7'h7F;
    if (!i_blank) begin
      unique case (i_nib)
        4'h0: o_seg = 7'h40;
        4'h1: o_seg = 7'h79;
        4'h2: o_seg = 7'h24;
        4'h3: o_seg = 7'h30;
        4'h4: o_seg = 7'h19;
        4'h5: o_seg = 7'h12;
        4'h6: o_seg = 7'h02;
        4'h7: o_seg = 7'h78;
        4'h8: o_seg = 7'h00;
        4'h9: o_seg = 7'h10;
        4'hA: o_seg = 7'h08;
        4'hB: o_seg = 7'h03;
        4'hC: o_seg = 7'h46;
        4'hD: o_seg = 7'h21;
        4'hE: o_seg = 7'h06;
        4'hF: o_seg = 7'h0E;
        default: o_seg = 7'h7F;
      endcase
    end
  end
endmodule

module seg7_bin_display #(
  parameter int WIDTH    = 16,
  parameter int DIGITS   = 5,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic                  iCLK_50,
  input  logic                  iRST_N,
  input  logic [WIDTH-1:0]      iBIN,
  input  logic                  iLOAD,
  input  logic                  iHEX_MODE,
  output logic                  oBUSY,
  output logic                  oDONE,
  output logic [7*DIGITS-1:0]   oSEG
);
  localparam int BW   = 4*DIGITS;
  localparam int CW   = $clog2(WIDTH+1);
  localparam int EXTW = (BW > WIDTH) ? BW : WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [WIDTH-1:0]  r_bin;
  logic [BW-1:0]     r_bcd, w_bcd_adj, w_bcd_next;
  logic [CW-1:0]     r_cnt;
  logic [BW-1:0]     r_dig;
  logic [EXTW-1:0]   w_bin_ext;
  logic [BW-1:0]     w_hex;
  logic [DIGITS-1:0] w_blank;

  assign w_bin_ext = EXTW'(iBIN);
  assign w_hex     = w_bin_ext[BW-1:0];

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < DIGITS; k++)
      if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
  end
  assign w_bcd_next = {w_bcd_adj[BW-2:0], r_bin[WIDTH-1]};

  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (iLOAD) w_next = iHEX_MODE ? S_DONE : S_SHIFT;
      S_SHIFT: if (r_cnt == CW'(1)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    oBUSY = (r_state != S_IDLE);
    oDONE = (r_state == S_DONE);
  end

  // Digit registers are written on the edge entering DONE, so oSEG already
  // carries the finished value in the cycle oDONE is high.
  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_dig <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (iLOAD) begin
          r_bin <= iBIN;
          r_bcd <= '0;
          r_cnt <= CW'(WIDTH);
          if (iHEX_MODE) r_dig <= w_hex;
        end
        S_SHIFT: begin
          r_bcd <= w_bcd_next;
          r_bin <= {r_bin[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_dig <= w_bcd_next;
        end
        default: ;
      endcase
    end
  end

  // Scan from the top digit down; a digit stays lit once any higher digit is non-zero.
  always_comb begin
    logic v_nz;
    v_nz    = 1'b0;
    w_blank = '0;
    for (int k = DIGITS-1; k >= 0; k--) begin
      v_nz       = v_nz | (|r_dig[4*k +: 4]);
      w_blank[k] = LZ_BLANK && (k != 0) && !v_nz;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    seg7_digit u_dig (
      .i_nib   (r_dig[4*g +: 4]),
      .i_blank (w_blank[g]),
      .o_seg   (oSEG[7*g +: 7])
    );
  end
endmodule

// File: tb/tb_seg7_bin_display.sv
// Scoreboard bench for seg7_bin_display (WIDTH=16, DIGITS=5, LZ_BLANK=1).

module tb_seg7_bin_display;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [15:0] bin = '0;
  logic        load = 1'b0, hexm = 1'b0;
  logic        busy, done;
  logic [34:0] seg;

  int          n_tests = 0, n_fail = 0, n_done = 0, cyc = 0;
  logic [34:0] exp_q[$];
  logic [34:0] prev_seg, mon_exp;
  bit          prev_ok = 1'b0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  seg7_bin_display #(.WIDTH(16), .DIGITS(5), .LZ_BLANK(1'b1)) dut (
    .iCLK_50(clk), .iRST_N(rst_n), .iBIN(bin), .iLOAD(load),
    .iHEX_MODE(hexm), .oBUSY(busy), .oDONE(done), .oSEG(seg)
  );

  function automatic logic [34:0] pk(input logic [6:0] d4, d3, d2, d1, d0);
    return {d4, d3, d2, d1, d0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every oDONE pops the scoreboard; between pulses oSEG must hold.
  always @(negedge clk) begin
    if (done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_done: oSEG=%h with no pending conversion", seg);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("scoreboard_oSEG", seg, mon_exp);
      end
    end else if (rst_n && prev_ok) begin
      chk("oSEG_hold", seg, prev_seg);
    end
    prev_seg = seg;
    prev_ok  = rst_n;
  end

  task automatic load_val(input logic [15:0] v, input logic h, input bit push, input logic [34:0] e);
    @(negedge clk);
    bin = v; hexm = h; load = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  task automatic measure(input string name, input int exp_lat);
    int k, busy_n, done_at;
    k = 0; busy_n = 0; done_at = 0;
    while (k < 100 && done_at == 0) begin
      @(negedge clk);
      k++;
      if (busy) busy_n++;
      if (done) done_at = k;
    end
    chk({name, "_latency"}, done_at, exp_lat);
    chk({name, "_busy_cycles"}, busy_n, exp_lat);
    @(negedge clk);
    chk({name, "_idle_after"}, busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [34:0] rst_seg;
    logic [15:0] t6v[4];
    logic [34:0] t6e[4];
    int d0, k, t_prev;
    rst_seg = pk(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40);

    repeat (3) @(negedge clk);
    chk("reset_oSEG", seg, rst_seg);
    chk("reset_oBUSY", busy, 1'b0);
    chk("reset_oDONE", done, 1'b0);
    rst_n = 1'b1;

    // T1
    load_val(16'd12345, 1'b0, 1'b1, pk(7'h79, 7'h24, 7'h30, 7'h19, 7'h12));
    measure("T1", 17);
    // T2
    load_val(16'd65535, 1'b0, 1'b1, pk(7'h02, 7'h12, 7'h12, 7'h30, 7'h12));
    measure("T2_max", 17);
    load_val(16'd0, 1'b0, 1'b1, rst_seg);
    measure("T2_zero", 17);
    // T3
    load_val(16'hBEEF, 1'b1, 1'b1, pk(7'h7F, 7'h03, 7'h06, 7'h06, 7'h0E));
    measure("T3_hex", 1);

    // T4: load while busy is ignored
    d0 = n_done;
    load_val(16'd100, 1'b0, 1'b1, pk(7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40));
    repeat (5) @(negedge clk);
    bin = 16'd999; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    repeat (40) @(negedge clk);
    chk("T4_single_done", n_done - d0, 1);

    // T5: reset mid-conversion
    d0 = n_done;
    load_val(16'd4321, 1'b0, 1'b0, '0);
    repeat (8) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("T5_reset_oSEG", seg, rst_seg);
    chk("T5_reset_oBUSY", busy, 1'b0);
    chk("T5_reset_oDONE", done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("T5_no_done", n_done - d0, 0);
    load_val(16'd7, 1'b0, 1'b1, pk(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78));
    measure("T5_after", 17);

    // T6: back-to-back with iLOAD held high
    t6v = '{16'd9, 16'd90, 16'd9, 16'd90};
    t6e = '{pk(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h10), pk(7'h7F, 7'h7F, 7'h7F, 7'h10, 7'h40),
            pk(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h10), pk(7'h7F, 7'h7F, 7'h7F, 7'h10, 7'h40)};
    @(negedge clk);
    bin = t6v[0]; hexm = 1'b0; load = 1'b1;
    exp_q.push_back(t6e[0]);
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!done && k < 40);
      chk("T6_done_seen", done, 1'b1);
      if (i > 0) chk("T6_period", cyc - t_prev, 18);
      t_prev = cyc;
      if (i < 3) begin
        bin = t6v[i+1];
        exp_q.push_back(t6e[i+1]);
      end else begin
        load = 1'b0;
      end
    end

    repeat (25) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
